// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one modexp engine: port 0 encrypts (E_ENC), port 1 decrypts (E_DEC).
// Optional watchdog: define ARB_TIMEOUT_EN to abort jobs that sit in BUSY for TIMEOUT_CYCLES.
module rsa_engine_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_MOD = 55,
  parameter int E_ENC = 23,
  parameter int E_DEC = 7
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp_err,
  output logic             eng_en,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_n,
  output logic [WIDTH-1:0] eng_e,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [WIDTH-1:0] LP_N_MOD = WIDTH'(N_MOD);
  localparam logic [WIDTH-1:0] LP_E_ENC = WIDTH'(E_ENC);
  localparam logic [WIDTH-1:0] LP_E_DEC = WIDTH'(E_DEC);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_GAP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic             r_eng_en;
  logic [WIDTH-1:0] r_eng_a;
  logic [WIDTH-1:0] r_eng_e;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_data;
  logic [WIDTH-1:0] r_rsp1_data;
  logic             r_rsp_err;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    r_timer;
`endif

  logic             w_idle;
  logic             w_sel;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;
  logic             w_range_err;

  // A tie goes to whichever port did not own the previous job.
  assign w_idle      = (r_state == S_IDLE);
  assign req0_ready  = w_idle & req0_valid & (~req1_valid | r_last_grant);
  assign req1_ready  = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept    = req0_ready | req1_ready;
  assign w_sel       = req1_ready;
  assign w_data      = w_sel ? req1_data : req0_data;
  assign w_range_err = (w_data >= LP_N_MOD);

  assign eng_n      = LP_N_MOD;
  assign eng_en     = r_eng_en;
  assign eng_a      = r_eng_a;
  assign eng_e      = r_eng_e;
  assign busy       = ~w_idle;
  assign grant_id   = r_grant;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign rsp_err    = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_eng_en     <= 1'b0;
      r_eng_a      <= '0;
      r_eng_e      <= LP_E_ENC;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
      r_rsp_err    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_timer      <= '0;
`endif
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_eng_a      <= w_data;
            r_eng_e      <= w_sel ? LP_E_DEC : LP_E_ENC;
            // Out-of-range operands are answered at once and never reach the engine.
            if (w_range_err) begin
              r_state   <= S_RESP;
              r_rsp_err <= 1'b1;
              if (w_sel) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_data  <= '0;
              end else begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_data  <= '0;
              end
            end else begin
              r_state  <= S_BUSY;
              r_eng_en <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              r_timer  <= '0;
`endif
            end
          end
        end
        S_BUSY: begin
          if (eng_done) begin
            r_eng_en <= 1'b0;
            r_state  <= S_RESP;
            if (r_grant) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_data  <= eng_result;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_data  <= eng_result;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_eng_en  <= 1'b0;
            r_state   <= S_RESP;
            r_rsp_err <= 1'b1;
            if (r_grant) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_data  <= '0;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_data  <= '0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        S_RESP:  r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Self-checking bench for rsa_engine_arbiter with a 12-cycle behavioural modexp engine.
// Expected results come from plain modular arithmetic and the round-robin/latency rules.
module tb_rsa_engine_arbiter;

  localparam int WIDTH   = 8;
  localparam int N_MOD   = 55;
  localparam int E_ENC   = 23;
  localparam int E_DEC   = 7;
  localparam int ENG_LAT = 12;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO     = 20;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0Valid = 1'b0, req1Valid = 1'b0;
  logic [WIDTH-1:0] req0Data = '0, req1Data = '0;
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
  logic [WIDTH-1:0] rsp0_data, rsp1_data, eng_a, eng_n, eng_e, eng_result;
  logic             eng_en, eng_done, busy, grant_id;
  logic             forceDone = 1'b0, engHang = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    logic       other;
    logic       enSeen;
    logic [7:0] e;
    logic       pulseOk;
    logic       grant;
  } jobObs_t;

  always #5 clk = ~clk;

  rsa_engine_arbiter #(
    .WIDTH(WIDTH), .N_MOD(N_MOD), .E_ENC(E_ENC), .E_DEC(E_DEC)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_data(req0Data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1Valid), .req1_data(req1Data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp_err(rsp_err), .eng_en(eng_en), .eng_a(eng_a), .eng_n(eng_n), .eng_e(eng_e),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [7:0] modexp(input logic [7:0] base, input logic [7:0] ex, input logic [7:0] m);
    int r;
    if (m == 8'd0) return 8'd0;
    r = 1 % int'(m);
    for (int i = 0; i < int'(ex); i++) r = (r * int'(base)) % int'(m);
    return 8'(r);
  endfunction

  function automatic logic [7:0] expectedResult(input bit port, input logic [7:0] data);
    if (int'(data) >= N_MOD) return 8'd0;
    return modexp(data, port ? 8'(E_DEC) : 8'(E_ENC), 8'(N_MOD));
  endfunction

  // Engine raises done ENG_LAT cycles after enable rises and holds it until enable drops.
  int   engCnt;
  logic engDoneQ;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      engCnt   <= 0;
      engDoneQ <= 1'b0;
    end else if (!eng_en) begin
      engCnt   <= 0;
      engDoneQ <= 1'b0;
    end else begin
      if (engCnt == ENG_LAT - 1 && !engHang) engDoneQ <= 1'b1;
      engCnt <= engCnt + 1;
    end
  end
  assign eng_done   = engDoneQ | forceDone;
  assign eng_result = engDoneQ ? modexp(eng_a, eng_e, eng_n) : 8'h00;

  task automatic resetDut();
    req0Valid = 1'b0; req1Valid = 1'b0; forceDone = 1'b0; engHang = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Drives one request and records what the DUT returns; latency counts the edge that samples rsp_valid.
  task automatic applyStimulus(input bit port, input logic [7:0] data, output jobObs_t obs);
    int waitCnt;
    int k;
    obs.data = 8'hxx; obs.err = 1'bx; obs.lat = -1; obs.other = 1'b0;
    obs.enSeen = 1'b0; obs.e = 8'hxx; obs.pulseOk = 1'b0; obs.grant = 1'bx;
    @(posedge clk); #1;
    if (port) begin req1Valid = 1'b1; req1Data = data; end
    else      begin req0Valid = 1'b1; req0Data = data; end
    #1;
    waitCnt = 0;
    while (!(port ? req1_ready : req0_ready) && waitCnt < 100) begin
      @(posedge clk); #2;
      waitCnt++;
    end
    if (waitCnt >= 100) begin
      req0Valid = 1'b0; req1Valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (port) req1Valid = 1'b0; else req0Valid = 1'b0;
    obs.e = eng_e; obs.grant = grant_id;
    k = 0;
    obs.enSeen = eng_en;
    while (!(rsp0_valid || rsp1_valid) && k < 500) begin
      @(posedge clk); #1;
      k++;
      obs.enSeen = obs.enSeen | eng_en;
    end
    if (k >= 500) return;
    obs.lat   = k + 1;
    obs.data  = port ? rsp1_data : rsp0_data;
    obs.err   = rsp_err;
    obs.other = port ? rsp0_valid : rsp1_valid;
    @(posedge clk); #1;
    obs.pulseOk = !rsp0_valid && !rsp1_valid && !rsp_err;
  endtask

  task automatic test_reset();
    resetDut();
    assertCount++; if ({busy, eng_en, grant_id, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready} !== 8'h00) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 00000000", {busy, eng_en, grant_id, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready}); end
    assertCount++; if ({eng_a, rsp0_data, rsp1_data} !== 24'h0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 000000", {eng_a, rsp0_data, rsp1_data}); end
    assertCount++; if (eng_e !== 8'(E_ENC)) begin failCount++; $display("[TB] FAIL reset_eng_e: got %0d expected %0d", eng_e, E_ENC); end
    assertCount++; if (eng_n !== 8'(N_MOD)) begin failCount++; $display("[TB] FAIL reset_eng_n: got %0d expected %0d", eng_n, N_MOD); end
    req1Valid = 1'b1; req1Data = 8'd5; #1;
    assertCount++; if ({req0_ready, req1_ready} !== 2'b01) begin failCount++; $display("[TB] FAIL idle_ready_single: got %b expected 01", {req0_ready, req1_ready}); end
    req1Valid = 1'b0; #1;
  endtask

  task automatic test_encrypt();
    jobObs_t o;
    applyStimulus(1'b0, 8'd2, o);
    assertCount++; if (o.data !== 8'd8) begin failCount++; $display("[TB] FAIL enc_data: got %0d expected 8", o.data); end
    assertCount++; if (o.lat !== ENG_LAT + 2) begin failCount++; $display("[TB] FAIL enc_latency: got %0d expected %0d", o.lat, ENG_LAT + 2); end
    assertCount++; if ({o.err, o.other, o.grant} !== 3'b000) begin failCount++; $display("[TB] FAIL enc_flags: got err/other/grant %b expected 000", {o.err, o.other, o.grant}); end
    assertCount++; if (o.e !== 8'(E_ENC)) begin failCount++; $display("[TB] FAIL enc_eng_e: got %0d expected %0d", o.e, E_ENC); end
    assertCount++; if ({o.enSeen, o.pulseOk} !== 2'b11) begin failCount++; $display("[TB] FAIL enc_en_pulse: got %b expected 11", {o.enSeen, o.pulseOk}); end
  endtask

  task automatic test_decrypt();
    jobObs_t o;
    applyStimulus(1'b1, 8'd8, o);
    assertCount++; if (o.data !== 8'd2) begin failCount++; $display("[TB] FAIL dec_data: got %0d expected 2", o.data); end
    assertCount++; if (o.e !== 8'(E_DEC)) begin failCount++; $display("[TB] FAIL dec_eng_e: got %0d expected %0d", o.e, E_DEC); end
    assertCount++; if ({o.err, o.other, o.grant, o.pulseOk} !== 4'b0011) begin failCount++; $display("[TB] FAIL dec_flags: got err/other/grant/pulse %b expected 0011", {o.err, o.other, o.grant, o.pulseOk}); end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [7:0] datas[$];
    int cyc;
    resetDut();
    @(posedge clk); #1;
    req0Valid = 1'b1; req0Data = 8'd2;
    req1Valid = 1'b1; req1Data = 8'd8;
    cyc = 0;
    while (order.size() < 4 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      assertCount++; if ((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready))) begin failCount++; $display("[TB] FAIL rr_ready_excl: got ready %b busy %b expected at most one ready, none when busy", {req0_ready, req1_ready}, busy); end
      if (rsp0_valid) begin order.push_back(0); datas.push_back(rsp0_data); end
      if (rsp1_valid) begin order.push_back(1); datas.push_back(rsp1_data); end
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    assertCount++; if (order.size() !== 4) begin failCount++; $display("[TB] FAIL rr_count: got %0d responses expected 4", order.size()); end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      assertCount++; if (order[i] !== (i % 2)) begin failCount++; $display("[TB] FAIL rr_order[%0d]: got port %0d expected %0d", i, order[i], i % 2); end
      assertCount++; if (datas[i] !== expectedResult(order[i] != 0, order[i] != 0 ? 8'd8 : 8'd2)) begin failCount++; $display("[TB] FAIL rr_data[%0d]: got %0d expected %0d", i, datas[i], expectedResult(order[i] != 0, order[i] != 0 ? 8'd8 : 8'd2)); end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_range_error();
    jobObs_t o;
    applyStimulus(1'b1, 8'd60, o);
    assertCount++; if ({o.err, o.data} !== {1'b1, 8'd0}) begin failCount++; $display("[TB] FAIL range_err: got err %b data %0d expected err 1 data 0", o.err, o.data); end
    assertCount++; if (o.lat !== 1) begin failCount++; $display("[TB] FAIL range_latency: got %0d expected 1", o.lat); end
    assertCount++; if ({o.enSeen, o.other, o.pulseOk} !== 3'b001) begin failCount++; $display("[TB] FAIL range_en_other_pulse: got %b expected 001", {o.enSeen, o.other, o.pulseOk}); end
  endtask

  task automatic test_stray_done();
    @(posedge clk); #1;
    forceDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      assertCount++; if ({busy, rsp0_valid, rsp1_valid, eng_en} !== 4'b0000) begin failCount++; $display("[TB] FAIL stray_done[%0d]: got busy/rsp0/rsp1/en %b expected 0000", i, {busy, rsp0_valid, rsp1_valid, eng_en}); end
    end
    forceDone = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int waitCnt;
    logic sawRsp;
    jobObs_t o;
    @(posedge clk); #1;
    req0Valid = 1'b1; req0Data = 8'd2;
    #1;
    waitCnt = 0;
    while (!req0_ready && waitCnt < 100) begin @(posedge clk); #2; waitCnt++; end
    @(posedge clk); #1;
    req0Valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    assertCount++; if ({eng_en, busy, rsp0_valid, rsp1_valid, rsp_err} !== 5'b00000) begin failCount++; $display("[TB] FAIL midreset_outputs: got en/busy/rsp0/rsp1/err %b expected 00000", {eng_en, busy, rsp0_valid, rsp1_valid, rsp_err}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sawRsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      sawRsp = sawRsp | rsp0_valid | rsp1_valid | eng_en;
    end
    assertCount++; if (sawRsp !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_lost_job: got activity %b expected 0", sawRsp); end
    applyStimulus(1'b0, 8'd3, o);
    assertCount++; if (o.data !== 8'd27) begin failCount++; $display("[TB] FAIL midreset_next_job: got %0d expected 27", o.data); end
  endtask

  task automatic test_random();
    jobObs_t o;
    bit port;
    logic [7:0] data;
    int expLat;
    for (int i = 0; i < 10; i++) begin
      port = 1'($urandom_range(0, 1));
      data = 8'($urandom_range(0, 70));
      expLat = (int'(data) >= N_MOD) ? 1 : ENG_LAT + 2;
      applyStimulus(port, data, o);
      assertCount++; if (o.data !== expectedResult(port, data)) begin failCount++; $display("[TB] FAIL rand_data[%0d] port %0d in %0d: got %0d expected %0d", i, port, data, o.data, expectedResult(port, data)); end
      assertCount++; if (o.err !== (int'(data) >= N_MOD)) begin failCount++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", i, o.err, int'(data) >= N_MOD); end
      assertCount++; if (o.lat !== expLat) begin failCount++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, o.lat, expLat); end
      assertCount++; if ({o.other, o.grant, o.pulseOk} !== {1'b0, port, 1'b1}) begin failCount++; $display("[TB] FAIL rand_flags[%0d]: got other/grant/pulse %b expected %b", i, {o.other, o.grant, o.pulseOk}, {1'b0, port, 1'b1}); end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    jobObs_t o;
    engHang = 1'b1;
    applyStimulus(1'b0, 8'd2, o);
    engHang = 1'b0;
    assertCount++; if ({o.err, o.data} !== {1'b1, 8'd0}) begin failCount++; $display("[TB] FAIL timeout_err: got err %b data %0d expected err 1 data 0", o.err, o.data); end
    assertCount++; if (o.lat !== TMO + 1) begin failCount++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", o.lat, TMO + 1); end
    applyStimulus(1'b1, 8'd8, o);
    assertCount++; if ({o.err, o.data} !== {1'b0, 8'd2}) begin failCount++; $display("[TB] FAIL timeout_rearm: got err %b data %0d expected err 0 data 2", o.err, o.data); end
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_round_robin();
    test_range_error();
    test_stray_done();
    test_reset_mid_job();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
